// File: rtl/count_display.sv
// Converts a 7-bit count to three BCD digits by double dabble and scans them
// onto a multiplexed three-digit seven-segment display with leading-zero blanking.
module count_display #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  value,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        valid
);

    localparam int unsigned SHIFTS = 7;
    localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_next;
    logic [6:0]          bin_work;
    logic [6:0]          last_val;
    logic [11:0]         bcd_work;
    logic [11:0]         bcd_adj_c;
    logic [2:0]          iter;
    logic                pending;
    logic                start_c;
    logic                last_shift_c;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          digit;
    logic [1:0]          digit_next_c;
    logic                wrap_c;
    logic                lit_c;
    logic [3:0]          nib_c;
    logic [6:0]          seg_hi_c;
    logic [2:0]          an_hi_c;

    assign start_c      = pending || (value != last_val);
    assign last_shift_c = (iter == 3'(SHIFTS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_c) state_next = SHIFT;
            SHIFT:   if (last_shift_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    always_comb begin
        bcd_adj_c = bcd_work;
        for (int d = 0; d < 3; d++) begin
            if (bcd_work[4*d +: 4] >= 4'd5) bcd_adj_c[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd      <= 12'h000;
            valid    <= 1'b0;
            busy     <= 1'b0;
            last_val <= 7'd0;
            pending  <= 1'b1;
            iter     <= 3'd0;
            bin_work <= 7'd0;
            bcd_work <= 12'h000;
        end else begin
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start_c) begin
                        bin_work <= value;
                        bcd_work <= 12'h000;
                        last_val <= value;
                        pending  <= 1'b0;
                        iter     <= 3'd0;
                    end
                end
                SHIFT: begin
                    bcd_work <= {bcd_adj_c[10:0], bin_work[6]};
                    bin_work <= {bin_work[5:0], 1'b0};
                    iter     <= iter + 3'd1;
                end
                DONE: begin
                    bcd   <= bcd_work;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wrap_c       = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign digit_next_c = (digit == 2'd2) ? 2'd0 : digit + 2'd1;

    // Digit selection and blanking for the slot that starts at the next wrap
    always_comb begin
        nib_c = bcd[3:0];
        lit_c = valid;
        case (digit_next_c)
            2'd1: begin
                nib_c = bcd[7:4];
                lit_c = valid && (bcd[11:4] != 8'h00);
            end
            2'd2: begin
                nib_c = bcd[11:8];
                lit_c = valid && (bcd[11:8] != 4'h0);
            end
            default: ;
        endcase
    end

    always_comb begin
        seg_hi_c = 7'h00;
        an_hi_c  = 3'b000;
        if (lit_c) begin
            an_hi_c = 3'(3'b001 << digit_next_c);
            case (nib_c)
                4'd0:    seg_hi_c = 7'b0111111;
                4'd1:    seg_hi_c = 7'b0000110;
                4'd2:    seg_hi_c = 7'b1011011;
                4'd3:    seg_hi_c = 7'b1001111;
                4'd4:    seg_hi_c = 7'b1100110;
                4'd5:    seg_hi_c = 7'b1101101;
                4'd6:    seg_hi_c = 7'b1111101;
                4'd7:    seg_hi_c = 7'b0000111;
                4'd8:    seg_hi_c = 7'b1111111;
                4'd9:    seg_hi_c = 7'b1101111;
                default: seg_hi_c = 7'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= 2'd0;
            seg      <= {7{ACTIVE_LOW}};
            an       <= {3{ACTIVE_LOW}};
        end else if (wrap_c) begin
            scan_cnt <= '0;
            digit    <= digit_next_c;
            seg      <= seg_hi_c ^ {7{ACTIVE_LOW}};
            an       <= an_hi_c ^ {3{ACTIVE_LOW}};
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display: scoreboarded BCD results plus scan/blanking checks.
module tb_count_display;

    logic        clk;
    logic        rst;
    logic [6:0]  value;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic [11:0] bcd;
    logic        busy;
    logic        valid;

    int          errors;
    int          checks;
    logic [11:0] exp_q[$];

    count_display #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .seg(seg),
        .an(an), .bcd(bcd), .busy(busy), .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_al(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
            5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; default: p = 7'h6F;
        endcase
        return ~p;
    endfunction

    task automatic wait_busy(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = busy;
        end
        chk({tag, "_start"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        chk({tag, "_done"}, 32'(ok), 32'd1);
    endtask

    // Aligns on the start of the ones slot and checks all 12 cycles of one scan
    task automatic scan_check(input int v, input string tag);
        logic [2:0] prev;
        logic [2:0] a_e;
        logic [6:0] s_e;
        bit         found;
        int         digs[3];
        bit         lit[3];
        digs[0] = v % 10; digs[1] = (v / 10) % 10; digs[2] = v / 100;
        lit[0]  = 1'b1;   lit[1]  = (v >= 10);     lit[2]  = (v >= 100);
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == 3'b110 && prev != 3'b110) found = 1'b1;
            else prev = an;
        end
        chk({tag, "_sync"}, 32'(found), 32'd1);
        if (found) begin
            for (int s = 0; s < 3; s++) begin
                for (int c = 0; c < 4; c++) begin
                    if (s != 0 || c != 0) @(negedge clk);
                    a_e = lit[s] ? 3'(~(3'b001 << s)) : 3'b111;
                    s_e = lit[s] ? seg_al(digs[s]) : 7'h7F;
                    chk($sformatf("%s_an_s%0d_c%0d", tag, s, c), 32'(an), 32'(a_e));
                    chk($sformatf("%s_seg_s%0d_c%0d", tag, s, c), 32'(seg), 32'(s_e));
                end
            end
        end
    endtask

    task automatic convert(input int v, input string tag);
        value = 7'(v);
        exp_q.push_back(to_bcd(v));
        wait_done(tag);
        repeat (12) @(negedge clk);
        scan_check(v, tag);
    endtask

    // Scoreboard: pops an expected result each time a valid conversion finishes
    initial begin
        logic  prev_busy;
        int    bcnt;
        logic [11:0] e;
        prev_busy = 1'b0;
        bcnt      = 0;
        forever begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
            end else if (prev_busy) begin
                if (valid) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected", 32'(bcd), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_bcd", 32'(bcd), 32'(e));
                        chk("sb_busy_len", 32'(bcnt), 32'd8);
                    end
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        value  = 7'd0;

        @(negedge clk);
        chk("rst_an", 32'(an), 32'h7);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h000);
        @(negedge clk);
        chk("rst2_an", 32'(an), 32'h7);
        chk("rst2_seg", 32'(seg), 32'h7F);
        rst = 1'b0;

        // Pending flag forces a conversion of zero
        exp_q.push_back(12'h000);
        wait_busy("zero");
        wait_done("zero");
        chk("zero_valid", 32'(valid), 32'd1);
        repeat (12) @(negedge clk);
        scan_check(0, "zero");

        // Unchanged value starts nothing
        begin
            bit idle_ok;
            idle_ok = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (busy) idle_ok = 1'b0;
            end
            chk("hold_idle", 32'(idle_ok), 32'd1);
        end

        convert(127, "v127");
        convert(99, "v99");
        convert(5, "v5");
        convert(10, "v10");

        // Value change mid-conversion is ignored, then picked up on return to idle
        value = 7'd5;
        exp_q.push_back(to_bcd(5));
        wait_busy("chg5");
        repeat (2) @(negedge clk);
        value = 7'd42;
        exp_q.push_back(to_bcd(42));
        wait_done("chg5");
        @(negedge clk);
        chk("chg_gap_busy", 32'(busy), 32'd1);
        chk("chg_bcd_hold", 32'(bcd), 32'h005);
        wait_done("chg42");
        repeat (12) @(negedge clk);
        scan_check(42, "v42");

        // Reset during SHIFT aborts; pending restarts the conversion
        value = 7'd100;
        wait_busy("abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'h000);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_an", 32'(an), 32'h7);
        chk("abort_seg", 32'(seg), 32'h7F);
        rst = 1'b0;
        exp_q.push_back(to_bcd(100));
        wait_busy("v100");
        wait_done("v100");
        chk("v100_bcd", 32'(bcd), 32'h100);
        repeat (12) @(negedge clk);
        scan_check(100, "v100");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, giving clock cycles per digit slot of the display scan (minimum 2).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1; when 1, seg and an are active-low, otherwise active-high.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port value  input  7  binary count from the upstream counter stage, range 0-127.
REQ-006 SHALL have port seg  output  7  segment drive, bit0=a … bit6=g.
REQ-007 SHALL have port an  output  3  digit enables, an[0]=ones, an[1]=tens, an[2]=hundreds.
REQ-008 SHALL have port bcd  output  12  last converted value, {hundreds,tens,ones} nibbles.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-010 SHALL have port valid  output  1  high once bcd holds at least one completed conversion.

Function
REQ-011 SHALL implement FSM IDLE, SHIFT, DONE; binary-to-BCD by shift-add-3 (double dabble), one shift per clock.
REQ-012 IDLE: if value != last captured value, or pending flag set, SHALL on that edge capture value, store it as last captured, clear pending, clear iteration count, go SHIFT.
REQ-013 SHIFT: each edge SHALL add 3 to every BCD nibble >= 5, then shift {bcd_work, bin_work} left one bit; after the 7th shift go DONE.
REQ-014 DONE: SHALL load bcd from working register, set valid=1, return to IDLE.
REQ-015 Latency SHALL be fixed: bcd updates on the 8th rising edge after the capturing edge (7 SHIFT edges + DONE edge).
REQ-016 busy SHALL be high in SHIFT and DONE, low in IDLE.
REQ-017 Changes on value during SHIFT/DONE SHALL be ignored; the comparison in IDLE on return starts a new conversion on the next edge.
REQ-018 bcd SHALL hold its value between conversions; no intermediate results visible on bcd.
REQ-019 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index SHALL advance 0→1→2→0.
REQ-020 Exactly one an bit SHALL be active during a non-blanked slot; none during a blanked slot.
REQ-021 Leading-zero blanking: hundreds blanked when 0; tens blanked when hundreds and tens both 0; ones never blanked once valid=1.
REQ-022 While valid=0 all digits SHALL be blanked.
REQ-023 seg SHALL use standard 0-9 patterns (active-high gfedcba: 0=0111111, 1=0000110, 7=0000111, 9=1101111); blanked slot drives all segments off.
REQ-024 seg and an SHALL be registered outputs, updated together with the digit index.

Reset
REQ-025 On rst=1 at a rising edge: state=IDLE, bcd=12'h000, valid=0, busy=0, last captured=0, pending=1, scan counter=0, digit index=0.
REQ-026 During and after reset until valid: an=3'b111 and seg=7'h7F (ACTIVE_LOW=1); 3'b000/7'h00 when ACTIVE_LOW=0.
REQ-027 rst asserted in SHIFT or DONE SHALL abort the conversion; bcd/valid are not updated by the aborted run.
REQ-028 pending=1 SHALL force a conversion on the first IDLE edge after reset release, even if value=0.

Verification
REQ-029 value=0, rst high 2 cycles then low -> an=111, seg=7F during reset; busy high 8 cycles; bcd=12'h000, valid=1; only ones slot lit, seg=7'b1000000.
REQ-030 value=7'd127 after idle -> busy 8 cycles, bcd=12'h127 on 8th edge after capture; an cycles 110,101,011 with seg for 7,2,1.
REQ-031 value=7'd99 -> bcd=12'h099; hundreds slot blanked (an=111, seg=7F for that slot); 7'd5 -> only ones lit.
REQ-032 value 5, changed to 42 on 3rd SHIFT edge -> bcd=12'h005 first, busy drops 1 cycle, then bcd=12'h042 8 edges after recapture.
REQ-033 rst pulsed during SHIFT of value 100 -> valid=0, bcd=0 next edge; after release conversion restarts, bcd=12'h100.
REQ-034 SCAN_DIV=4, value 123 -> each an pattern held exactly 4 cycles, full scan period 12 cycles.
